// File: rtl/xadc_drp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xadc_drp_arbiter: shares the XADC DRP between an EOC-driven sample reader |
// | and a configuration requester, one transaction outstanding at a time.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module xadc_drp_arbiter #(
  parameter logic [6:0]  SAMPLE_ADDR    = 7'h03,
  parameter int unsigned BIPOLAR        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               xadc_eoc,
  output logic [6:0]         drp_daddr,
  output logic               drp_den,
  output logic               drp_dwe,
  output logic [15:0]        drp_di,
  input  logic [15:0]        drp_do,
  input  logic               drp_drdy,
  output logic signed [15:0] sample_data,
  output logic               sample_valid,
  input  logic               cfg_req,
  input  logic               cfg_we,
  input  logic [6:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic               cfg_ack,
  output logic [15:0]        cfg_rdata,
  output logic               cfg_err,
  output logic [7:0]         overrun_cnt,
  output logic               timeout_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic       GRANT_SAMPLE = 1'b0;
  localparam logic       GRANT_CFG    = 1'b1;
  // Last WAIT count value before the timeout fires; DONE lands TIMEOUT_CYCLES after drp_den.
  localparam logic [7:0] WAIT_LAST    = 8'(TIMEOUT_CYCLES - 2);

  state_t      state;
  logic        sample_pending;
  logic        last_grant;
  logic        txn_cfg;
  logic        txn_we;
  logic [7:0]  wait_cnt;
  logic        eoc_set;
  logic        grant_sample;
  logic        grant_cfg;
  logic [15:0] conv_data;

  assign eoc_set   = xadc_eoc & enable;
  assign conv_data = (BIPOLAR != 0) ? {drp_do[15:4], 4'b0000}
                                    : {~drp_do[15], drp_do[14:4], 4'b0000};

  always_comb begin
    grant_sample = 1'b0;
    grant_cfg    = 1'b0;
    if (state == IDLE) begin
      if (sample_pending && cfg_req) begin
        if (last_grant == GRANT_SAMPLE) grant_cfg    = 1'b1;
        else                            grant_sample = 1'b1;
      end else if (sample_pending) begin
        grant_sample = 1'b1;
      end else if (cfg_req) begin
        grant_cfg = 1'b1;
      end
    end
  end

  // An EOC coinciding with the sample grant re-arms the request without counting a loss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_pending <= 1'b0;
      overrun_cnt    <= 8'd0;
    end else begin
      sample_pending <= eoc_set | (sample_pending & ~grant_sample);
      if (eoc_set && sample_pending && !grant_sample && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= GRANT_SAMPLE;
      txn_cfg      <= 1'b0;
      txn_we       <= 1'b0;
      wait_cnt     <= 8'd0;
      drp_daddr    <= 7'd0;
      drp_den      <= 1'b0;
      drp_dwe      <= 1'b0;
      drp_di       <= 16'd0;
      sample_data  <= 16'sd0;
      sample_valid <= 1'b0;
      cfg_ack      <= 1'b0;
      cfg_rdata    <= 16'd0;
      cfg_err      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_sample || grant_cfg) begin
            state      <= ISSUE;
            drp_den    <= 1'b1;
            txn_cfg    <= grant_cfg;
            last_grant <= grant_cfg ? GRANT_CFG : GRANT_SAMPLE;
            if (grant_cfg) begin
              txn_we    <= cfg_we;
              drp_daddr <= cfg_addr;
              drp_dwe   <= cfg_we;
              drp_di    <= cfg_wdata;
            end else begin
              txn_we    <= 1'b0;
              drp_daddr <= SAMPLE_ADDR;
              drp_dwe   <= 1'b0;
              drp_di    <= 16'd0;
            end
          end
        end
        ISSUE: begin
          state     <= WAIT;
          drp_den   <= 1'b0;
          drp_daddr <= 7'd0;
          drp_dwe   <= 1'b0;
          drp_di    <= 16'd0;
          wait_cnt  <= 8'd0;
        end
        WAIT: begin
          if (drp_drdy) begin
            state <= DONE;
            if (txn_cfg) begin
              cfg_ack   <= 1'b1;
              cfg_err   <= 1'b0;
              cfg_rdata <= txn_we ? 16'd0 : drp_do;
            end else begin
              sample_valid <= 1'b1;
              sample_data  <= conv_data;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              state        <= DONE;
              timeout_flag <= 1'b1;
              if (txn_cfg) begin
                cfg_ack   <= 1'b1;
                cfg_err   <= 1'b1;
                cfg_rdata <= 16'd0;
              end
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          sample_valid <= 1'b0;
          cfg_ack      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_arbiter.sv
`default_nettype none
// Bench for xadc_drp_arbiter: bipolar and unipolar instances share one stimulus and DRP responder.
module tb_xadc_drp_arbiter;

  typedef struct { logic [15:0] dout; logic [15:0] exp_bip; logic [15:0] exp_uni; } svec_t;
  typedef struct { logic [15:0] eb; logic [15:0] eu; } sexp_t;
  typedef struct { logic [15:0] rdata; logic err; } cexp_t;
  typedef struct { logic [6:0] addr; logic we; logic [15:0] di; logic chk_di; } op_t;

  logic clk = 1'b0;
  logic reset = 1'b0, enable = 1'b0, xadc_eoc = 1'b0;
  logic [15:0] drp_do = 16'd0;
  logic drp_drdy = 1'b0;
  logic cfg_req = 1'b0, cfg_we = 1'b0;
  logic [6:0] cfg_addr = 7'd0;
  logic [15:0] cfg_wdata = 16'd0;

  logic [6:0] daddr_b, daddr_u;
  logic den_b, den_u, dwe_b, dwe_u, svalid_b, svalid_u, ack_b, ack_u, err_b, err_u, tof_b, tof_u;
  logic [15:0] di_b, di_u, sdata_b, sdata_u, rdata_b, rdata_u;
  logic [7:0] ovr_b, ovr_u;

  int checks = 0, errors = 0;
  int cyc = 0, n_den = 0, n_valid = 0, n_ack = 0;
  int den_cyc = 0, drdy_cyc = 0, valid_cyc = 0, ack_cyc = 0;
  int resp_cnt = 0, resp_delay = 1;
  logic resp_on = 1'b1, free_run = 1'b0, den_prev = 1'b0;
  logic [15:0] resp_data = 16'd0;

  sexp_t sq[$];
  cexp_t cq[$];
  op_t   op_q[$];
  svec_t tbl[6];

  always #5 clk = ~clk;

  xadc_drp_arbiter #(.SAMPLE_ADDR(7'h03), .BIPOLAR(1), .TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .xadc_eoc(xadc_eoc),
    .drp_daddr(daddr_b), .drp_den(den_b), .drp_dwe(dwe_b), .drp_di(di_b),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .sample_data(sdata_b), .sample_valid(svalid_b),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(ack_b), .cfg_rdata(rdata_b), .cfg_err(err_b),
    .overrun_cnt(ovr_b), .timeout_flag(tof_b));

  xadc_drp_arbiter #(.SAMPLE_ADDR(7'h03), .BIPOLAR(0), .TIMEOUT_CYCLES(64)) dut_u (
    .clk(clk), .reset(reset), .enable(enable), .xadc_eoc(xadc_eoc),
    .drp_daddr(daddr_u), .drp_den(den_u), .drp_dwe(dwe_u), .drp_di(di_u),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .sample_data(sdata_u), .sample_valid(svalid_u),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(ack_u), .cfg_rdata(rdata_u), .cfg_err(err_u),
    .overrun_cnt(ovr_u), .timeout_flag(tof_u));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive the DRP responder, then score whatever the DUTs produced.
  task automatic tick();
    sexp_t s;
    cexp_t c;
    op_t   o;
    @(negedge clk);
    cyc++;
    drp_drdy = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0 && resp_on) begin
        drp_drdy = 1'b1;
        drp_do   = resp_data;
        drdy_cyc = cyc;
      end
    end
    if (den_prev) chk("den_single_cycle", 32'(den_b), 32'd0);
    if (den_b) begin
      n_den++;
      den_cyc  = cyc;
      resp_cnt = resp_delay;
      if (!free_run) begin
        chk("op_expected", 32'(op_q.size() != 0), 32'd1);
        if (op_q.size() != 0) begin
          o = op_q.pop_front();
          chk("drp_daddr", 32'(daddr_b), 32'(o.addr));
          chk("drp_dwe", 32'(dwe_b), 32'(o.we));
          if (o.chk_di) chk("drp_di", 32'(di_b), 32'(o.di));
        end
      end
    end else begin
      chk("bus_idle_zero", 32'({daddr_b, dwe_b, di_b}), 32'd0);
    end
    den_prev = den_b;
    chk("valid_uni_match", 32'(svalid_u), 32'(svalid_b));
    if (svalid_b) begin
      n_valid++;
      valid_cyc = cyc;
      if (!free_run) begin
        chk("sample_expected", 32'(sq.size() != 0), 32'd1);
        if (sq.size() != 0) begin
          s = sq.pop_front();
          chk("sample_data_bipolar", 32'(sdata_b), 32'(s.eb));
          chk("sample_data_unipolar", 32'(sdata_u), 32'(s.eu));
        end
      end
    end
    if (ack_b) begin
      n_ack++;
      ack_cyc = cyc;
      chk("cfg_ack_expected", 32'(cq.size() != 0), 32'd1);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        chk("cfg_rdata", 32'(rdata_b), 32'(c.rdata));
        chk("cfg_err", 32'(err_b), 32'(c.err));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_drp_bus"}, 32'({daddr_b, den_b, dwe_b, di_b}), 32'd0);
    chk({tag, "_sample"}, 32'({sdata_b, svalid_b}), 32'd0);
    chk({tag, "_cfg"}, 32'({ack_b, rdata_b, err_b}), 32'd0);
    chk({tag, "_status"}, 32'({ovr_b, tof_b}), 32'd0);
  endtask

  task automatic do_sample(input logic [15:0] d, input logic [15:0] eb, input logic [15:0] eu,
                           input int delay);
    int v0, d0, e_cyc;
    v0 = n_valid;
    d0 = n_den;
    resp_data = d; resp_delay = delay; resp_on = 1'b1;
    op_q.push_back('{addr: 7'h03, we: 1'b0, di: 16'h0, chk_di: 1'b0});
    sq.push_back('{eb: eb, eu: eu});
    xadc_eoc = 1'b1;
    e_cyc = cyc;
    tick();
    xadc_eoc = 1'b0;
    for (int i = 0; i < 100 && n_valid == v0; i++) tick();
    chk("eoc_to_den_latency", 32'(den_cyc - e_cyc), 32'd2);
    chk("drdy_to_valid_latency", 32'(valid_cyc - drdy_cyc), 32'd1);
    run(3);
    chk("one_sample_valid", 32'(n_valid - v0), 32'd1);
    chk("one_den", 32'(n_den - d0), 32'd1);
  endtask

  task automatic do_cfg(input logic we, input logic [6:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int delay, input logic on,
                        input logic [15:0] exp_rdata, input logic exp_err);
    int a0;
    a0 = n_ack;
    resp_data = rd; resp_delay = delay; resp_on = on;
    op_q.push_back('{addr: a, we: we, di: wd, chk_di: 1'b1});
    cq.push_back('{rdata: exp_rdata, err: exp_err});
    cfg_we = we; cfg_addr = a; cfg_wdata = wd; cfg_req = 1'b1;
    for (int i = 0; i < 200 && n_ack == a0; i++) tick();
    cfg_req = 1'b0;
    chk("cfg_ack_count", 32'(n_ack - a0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, v0, d0;
    tbl[0] = '{dout: 16'hABCD, exp_bip: 16'hABC0, exp_uni: 16'h2BC0};
    tbl[1] = '{dout: 16'h8000, exp_bip: 16'h8000, exp_uni: 16'h0000};
    tbl[2] = '{dout: 16'h0010, exp_bip: 16'h0010, exp_uni: 16'h8010};
    tbl[3] = '{dout: 16'h7FFF, exp_bip: 16'h7FF0, exp_uni: 16'hFFF0};
    tbl[4] = '{dout: 16'hFFFF, exp_bip: 16'hFFF0, exp_uni: 16'h7FF0};
    tbl[5] = '{dout: 16'h0000, exp_bip: 16'h0000, exp_uni: 16'h8000};

    run(3);
    check_all_zero("reset_state");
    reset = 1'b1;
    enable = 1'b1;
    run(2);

    for (int i = 0; i < 6; i++)
      do_sample(tbl[i].dout, tbl[i].exp_bip, tbl[i].exp_uni, (i == 0) ? 3 : 1 + (i % 3));

    do_cfg(1'b1, 7'h41, 16'h1234, 16'hDEAD, 1, 1'b1, 16'h0000, 1'b0);
    do_cfg(1'b0, 7'h41, 16'h0000, 16'h5555, 2, 1'b1, 16'h5555, 1'b0);
    run(2);

    // Contention: cfg held while EOC pulses every 10 cycles, DRP answers 2 cycles after den.
    a0 = n_ack; v0 = n_valid;
    resp_data = 16'h0F0F; resp_delay = 2; resp_on = 1'b1;
    cfg_we = 1'b0; cfg_addr = 7'h10; cfg_wdata = 16'h00A5;
    op_q.push_back('{addr: 7'h03, we: 1'b0, di: 16'h0, chk_di: 1'b0});
    op_q.push_back('{addr: 7'h10, we: 1'b0, di: 16'h00A5, chk_di: 1'b1});
    op_q.push_back('{addr: 7'h03, we: 1'b0, di: 16'h0, chk_di: 1'b0});
    op_q.push_back('{addr: 7'h10, we: 1'b0, di: 16'h00A5, chk_di: 1'b1});
    op_q.push_back('{addr: 7'h03, we: 1'b0, di: 16'h0, chk_di: 1'b0});
    for (int k = 0; k < 3; k++) sq.push_back('{eb: 16'h0F00, eu: 16'h8F00});
    for (int k = 0; k < 2; k++) cq.push_back('{rdata: 16'h0F0F, err: 1'b0});
    for (int i = 0; i < 45; i++) begin
      xadc_eoc = (i % 10 == 0) && (i < 30);
      if (i == 1) cfg_req = 1'b1;
      tick();
      if (n_ack - a0 == 2) cfg_req = 1'b0;
    end
    xadc_eoc = 1'b0;
    chk("contention_samples", 32'(n_valid - v0), 32'd3);
    chk("contention_cfgs", 32'(n_ack - a0), 32'd2);
    run(3);

    // Overrun: three EOCs while a cfg read sits in WAIT.
    chk("overrun_before", 32'(ovr_b), 32'd0);
    a0 = n_ack; v0 = n_valid;
    resp_data = 16'h1357; resp_delay = 20; resp_on = 1'b1;
    cfg_we = 1'b0; cfg_addr = 7'h20; cfg_wdata = 16'h0000;
    op_q.push_back('{addr: 7'h20, we: 1'b0, di: 16'h0000, chk_di: 1'b1});
    op_q.push_back('{addr: 7'h03, we: 1'b0, di: 16'h0, chk_di: 1'b0});
    cq.push_back('{rdata: 16'h1357, err: 1'b0});
    sq.push_back('{eb: 16'h1350, eu: 16'h9350});
    cfg_req = 1'b1;
    for (int i = 0; i < 80 && n_valid == v0; i++) begin
      xadc_eoc = (i == 5) || (i == 8) || (i == 11);
      tick();
      if (n_ack != a0) begin cfg_req = 1'b0; resp_delay = 1; end
    end
    xadc_eoc = 1'b0;
    cfg_req = 1'b0;
    chk("overrun_cnt_two", 32'(ovr_b), 32'd2);
    chk("overrun_one_sample", 32'(n_valid - v0), 32'd1);
    run(3);

    // Timeout: withhold drdy on a cfg read.
    chk("timeout_flag_clear", 32'(tof_b), 32'd0);
    do_cfg(1'b0, 7'h22, 16'h0000, 16'hBEEF, 1, 1'b0, 16'h0000, 1'b1);
    chk("timeout_latency", 32'(ack_cyc - den_cyc), 32'd64);
    chk("timeout_flag_set", 32'(tof_b), 32'd1);
    resp_on = 1'b1;
    run(2);

    // Overrun saturation: continuous EOC for 500 cycles.
    free_run = 1'b1; resp_data = 16'hCAFE; resp_delay = 1;
    xadc_eoc = 1'b1;
    run(500);
    xadc_eoc = 1'b0;
    run(20);
    free_run = 1'b0;
    chk("overrun_saturated", 32'(ovr_b), 32'd255);

    // Reset while a cfg read waits for drdy; the late drdy must be ignored.
    a0 = n_ack; v0 = n_valid; d0 = n_den;
    resp_data = 16'h7777; resp_delay = 10; resp_on = 1'b1;
    cfg_we = 1'b0; cfg_addr = 7'h30; cfg_wdata = 16'h0000;
    op_q.push_back('{addr: 7'h30, we: 1'b0, di: 16'h0000, chk_di: 1'b1});
    cfg_req = 1'b1;
    for (int i = 0; i < 20 && n_den == d0; i++) tick();
    chk("reset_test_den", 32'(n_den - d0), 32'd1);
    run(3);
    reset = 1'b0;
    cfg_req = 1'b0;
    #1;
    check_all_zero("reset_mid_txn");
    tick();
    reset = 1'b1;
    run(15);
    chk("late_drdy_no_ack", 32'(n_ack - a0), 32'd0);
    chk("late_drdy_no_sample", 32'(n_valid - v0), 32'd0);
    chk("late_drdy_no_den", 32'(n_den - d0), 32'd1);

    chk("op_queue_drained", 32'(op_q.size()), 32'd0);
    chk("sample_queue_drained", 32'(sq.size()), 32'd0);
    chk("cfg_queue_drained", 32'(cq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
